// File: rtl/counter_chain_if.sv
// Bus bundle for counter_chain: control, per-level max/stride inputs and count/done outputs.
// The optional wrap counter port exists only when COUNTER_CHAIN_WRAP_COUNT_EN is defined.
interface counter_chain_if #(
    parameter int LEVELS = 2,
    parameter int WIDTH  = 6
);
    logic                      io_input_reset;
    logic                      io_input_enable;
    logic                      io_input_saturate;
    logic [LEVELS*WIDTH-1:0]   io_input_maxes;
    logic [LEVELS*WIDTH-1:0]   io_input_strides;
    logic [LEVELS*WIDTH-1:0]   io_output_counts;
    logic [LEVELS-1:0]         io_output_dones;
    logic                      io_output_done;
    logic                      io_output_saturated;
`ifdef COUNTER_CHAIN_WRAP_COUNT_EN
    logic [WIDTH-1:0]          io_output_wraps;
`endif

    modport master (
        output io_input_reset, io_input_enable, io_input_saturate,
        output io_input_maxes, io_input_strides,
        input  io_output_counts, io_output_dones, io_output_done, io_output_saturated
`ifdef COUNTER_CHAIN_WRAP_COUNT_EN
        , input io_output_wraps
`endif
    );

    modport slave (
        input  io_input_reset, io_input_enable, io_input_saturate,
        input  io_input_maxes, io_input_strides,
        output io_output_counts, io_output_dones, io_output_done, io_output_saturated
`ifdef COUNTER_CHAIN_WRAP_COUNT_EN
        , output io_output_wraps
`endif
    );
endinterface

// File: rtl/counter_chain.sv
// Chain of LEVELS nested counters (level 0 innermost) with live max/stride, done flags and saturate mode.
// Counts are registered; done flags are combinational from state. Macro COUNTER_CHAIN_WRAP_COUNT_EN adds a wrap counter.
module counter_chain #(
    parameter int LEVELS = 2,
    parameter int WIDTH  = 6
) (
    input  logic          clock,
    input  logic          reset,
    counter_chain_if.slave bus
);
    logic [WIDTH-1:0]  r_count [LEVELS];
    logic              r_saturated;

    logic [WIDTH-1:0]  w_max   [LEVELS];
    logic [WIDTH-1:0]  w_step  [LEVELS];
    logic [WIDTH:0]    w_sum   [LEVELS];
    logic [LEVELS-1:0] w_last;
    logic [LEVELS-1:0] w_dones;
    logic [LEVELS-1:0] w_adv;
    logic              w_clear;
    logic              w_hit_end;

    assign w_clear = reset | bus.io_input_reset;

    // Sum is one bit wider than the count so max = 2^WIDTH-1 cannot overflow the compare.
    always_comb begin
        for (int i = 0; i < LEVELS; i++) begin
            w_max[i]  = bus.io_input_maxes[i*WIDTH +: WIDTH];
            w_step[i] = (bus.io_input_strides[i*WIDTH +: WIDTH] == '0) ?
                        WIDTH'(1) : bus.io_input_strides[i*WIDTH +: WIDTH];
            w_sum[i]  = {1'b0, r_count[i]} + {1'b0, w_step[i]};
            w_last[i] = (w_sum[i] > {1'b0, w_max[i]});
        end
    end

    always_comb begin
        logic v_done;
        logic v_adv;
        w_dones = '0;
        w_adv   = '0;
        v_done  = 1'b1;
        v_adv   = bus.io_input_enable & ~r_saturated;
        for (int i = 0; i < LEVELS; i++) begin
            w_adv[i]   = v_adv;
            v_done     = v_done & w_last[i];
            w_dones[i] = v_done;
            v_adv      = v_adv & w_last[i];
        end
    end

    assign w_hit_end = w_adv[0] & w_dones[LEVELS-1];

    always_ff @(posedge clock) begin
        if (w_clear) begin
            for (int i = 0; i < LEVELS; i++) begin
                r_count[i] <= '0;
            end
            r_saturated <= 1'b0;
        end else if (w_hit_end & bus.io_input_saturate) begin
            r_saturated <= 1'b1;
        end else begin
            for (int i = 0; i < LEVELS; i++) begin
                if (w_adv[i]) begin
                    r_count[i] <= w_last[i] ? '0 : w_sum[i][WIDTH-1:0];
                end
            end
        end
    end

`ifdef COUNTER_CHAIN_WRAP_COUNT_EN
    logic [WIDTH-1:0] r_wraps;

    // Sticks at all-ones rather than rolling over.
    always_ff @(posedge clock) begin
        if (w_clear) begin
            r_wraps <= '0;
        end else if (w_hit_end & ~bus.io_input_saturate & (r_wraps != '1)) begin
            r_wraps <= r_wraps + WIDTH'(1);
        end
    end

    assign bus.io_output_wraps = r_wraps;
`endif

    always_comb begin
        bus.io_output_counts = '0;
        for (int i = 0; i < LEVELS; i++) begin
            bus.io_output_counts[i*WIDTH +: WIDTH] = r_count[i];
        end
    end

    assign bus.io_output_dones     = w_dones;
    assign bus.io_output_done      = w_dones[LEVELS-1];
    assign bus.io_output_saturated = r_saturated;
endmodule

// File: tb/tb_counter_chain.sv
// Directed bench for counter_chain: a 2-level instance driven from a vector table plus
// hand-written corner sequences, and a 1-level instance covering the full 6-bit range.
module tb_counter_chain;
    logic clock = 1'b0;
    logic reset;
    int   checks   = 0;
    int   failures = 0;

    always #5 clock = ~clock;

    counter_chain_if #(.LEVELS(2), .WIDTH(6)) b2 ();
    counter_chain_if #(.LEVELS(1), .WIDTH(6)) b1 ();

    counter_chain #(.LEVELS(2), .WIDTH(6)) u2 (.clock(clock), .reset(reset), .bus(b2.slave));
    counter_chain #(.LEVELS(1), .WIDTH(6)) u1 (.clock(clock), .reset(reset), .bus(b1.slave));

    typedef struct {
        logic       en;
        logic       sat;
        logic       srst;
        logic [5:0] mx0;
        logic [5:0] mx1;
        logic [5:0] st0;
        logic [5:0] st1;
        logic [5:0] c0;
        logic [5:0] c1;
        logic [1:0] dn;
        logic       sd;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic set2(input logic en, input logic sat, input logic srst,
                        input logic [5:0] mx0, input logic [5:0] mx1,
                        input logic [5:0] st0, input logic [5:0] st1);
        b2.io_input_enable   = en;
        b2.io_input_saturate = sat;
        b2.io_input_reset    = srst;
        b2.io_input_maxes    = {mx1, mx0};
        b2.io_input_strides  = {st1, st0};
    endtask

    task automatic chk2(input string name, input logic [5:0] c0, input logic [5:0] c1,
                        input logic [1:0] dn, input logic sd);
        chk({name, "_counts"}, 64'(b2.io_output_counts), 64'({c1, c0}));
        chk({name, "_dones"}, 64'(b2.io_output_dones), 64'(dn));
        chk({name, "_done"}, 64'(b2.io_output_done), 64'(dn[1]));
        chk({name, "_sat"}, 64'(b2.io_output_saturated), 64'(sd));
    endtask

    initial begin
        logic [5:0] e;

        // Wrap sequence over maxes {3,2}, stride 1.
        vecs.push_back('{1,0,0, 3,2, 1,1, 1,0, 2'b00, 0});
        vecs.push_back('{1,0,0, 3,2, 1,1, 2,0, 2'b00, 0});
        vecs.push_back('{1,0,0, 3,2, 1,1, 3,0, 2'b01, 0});
        vecs.push_back('{1,0,0, 3,2, 1,1, 0,1, 2'b00, 0});
        vecs.push_back('{1,0,0, 3,2, 1,1, 1,1, 2'b00, 0});
        vecs.push_back('{1,0,0, 3,2, 1,1, 2,1, 2'b00, 0});
        vecs.push_back('{1,0,0, 3,2, 1,1, 3,1, 2'b01, 0});
        vecs.push_back('{1,0,0, 3,2, 1,1, 0,2, 2'b00, 0});
        vecs.push_back('{1,0,0, 3,2, 1,1, 1,2, 2'b00, 0});
        vecs.push_back('{1,0,0, 3,2, 1,1, 2,2, 2'b00, 0});
        vecs.push_back('{1,0,0, 3,2, 1,1, 3,2, 2'b11, 0});
        vecs.push_back('{1,0,0, 3,2, 1,1, 0,0, 2'b00, 0});
        // Inner max 5 stride 2, then stride 0 acting as 1.
        vecs.push_back('{1,0,0, 5,2, 2,1, 2,0, 2'b00, 0});
        vecs.push_back('{1,0,0, 5,2, 2,1, 4,0, 2'b01, 0});
        vecs.push_back('{1,0,0, 5,2, 2,1, 0,1, 2'b00, 0});
        vecs.push_back('{1,0,0, 5,2, 2,1, 2,1, 2'b00, 0});
        vecs.push_back('{1,0,0, 5,2, 0,1, 3,1, 2'b00, 0});
        vecs.push_back('{1,0,0, 5,2, 0,1, 4,1, 2'b00, 0});
        vecs.push_back('{1,0,0, 5,2, 0,1, 5,1, 2'b01, 0});
        vecs.push_back('{1,0,0, 5,2, 0,1, 0,2, 2'b00, 0});
        vecs.push_back('{0,0,0, 5,2, 0,1, 0,2, 2'b00, 0});
        vecs.push_back('{0,0,0, 5,2, 0,1, 0,2, 2'b00, 0});
        // Soft clear together with enable: clear wins.
        vecs.push_back('{1,0,1, 3,2, 1,1, 0,0, 2'b00, 0});

        reset = 1'b1;
        set2(0, 0, 0, 6'd3, 6'd2, 6'd1, 6'd1);
        b1.io_input_enable   = 1'b0;
        b1.io_input_saturate = 1'b0;
        b1.io_input_reset    = 1'b0;
        b1.io_input_maxes    = 6'd63;
        b1.io_input_strides  = 6'd1;
        step();
        step();
        chk2("reset", 6'd0, 6'd0, 2'b00, 1'b0);
        reset = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            set2(vecs[i].en, vecs[i].sat, vecs[i].srst, vecs[i].mx0, vecs[i].mx1,
                 vecs[i].st0, vecs[i].st1);
            step();
            chk2($sformatf("vec%0d", i), vecs[i].c0, vecs[i].c1, vecs[i].dn, vecs[i].sd);
        end

        // Hold with enable low at (2,1), then hard reset mid-run.
        set2(1, 0, 0, 6'd3, 6'd2, 6'd1, 6'd1);
        for (int i = 0; i < 6; i++) step();
        chk2("hold_pre", 6'd2, 6'd1, 2'b00, 1'b0);
        b2.io_input_enable = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            chk2($sformatf("hold%0d", i), 6'd2, 6'd1, 2'b00, 1'b0);
        end
        b2.io_input_enable = 1'b1;
        step();
        step();
        chk2("run_02", 6'd0, 6'd2, 2'b00, 1'b0);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk2("hard_rst", 6'd0, 6'd0, 2'b00, 1'b0);

        // Saturate at (3,2) and stay there.
        set2(1, 1, 0, 6'd3, 6'd2, 6'd1, 6'd1);
        for (int i = 0; i < 11; i++) step();
        chk2("sat_reach", 6'd3, 6'd2, 2'b11, 1'b0);
        step();
        chk2("sat_set", 6'd3, 6'd2, 2'b11, 1'b1);
        for (int i = 0; i < 10; i++) begin
            step();
            chk2($sformatf("sat_hold%0d", i), 6'd3, 6'd2, 2'b11, 1'b1);
        end
        set2(1, 1, 1, 6'd3, 6'd2, 6'd1, 6'd1);
        step();
        chk2("sat_clear", 6'd0, 6'd0, 2'b00, 1'b0);

        // Inner max 0: inner pinned at 0 and always last.
        set2(1, 0, 0, 6'd0, 6'd2, 6'd1, 6'd1);
        step();
        chk2("max0_a", 6'd0, 6'd1, 2'b01, 1'b0);
        step();
        chk2("max0_b", 6'd0, 6'd2, 2'b11, 1'b0);
        step();
        chk2("max0_c", 6'd0, 6'd0, 2'b01, 1'b0);

        // Max dropped below current count: last immediately, wraps on next advance.
        set2(1, 0, 0, 6'd3, 6'd2, 6'd1, 6'd1);
        step();
        step();
        chk2("drop_pre", 6'd2, 6'd0, 2'b00, 1'b0);
        b2.io_input_enable = 1'b0;
        b2.io_input_maxes  = {6'd2, 6'd1};
        #1;
        chk2("drop_live", 6'd2, 6'd0, 2'b01, 1'b0);
        b2.io_input_enable = 1'b1;
        step();
        chk2("drop_wrap", 6'd0, 6'd1, 2'b00, 1'b0);

`ifdef COUNTER_CHAIN_WRAP_COUNT_EN
        set2(1, 0, 1, 6'd3, 6'd2, 6'd1, 6'd1);
        step();
        chk("wraps_clear", 64'(b2.io_output_wraps), 64'd0);
        b2.io_input_reset = 1'b0;
        for (int i = 0; i < 36; i++) step();
        chk("wraps_3", 64'(b2.io_output_wraps), 64'd3);
        set2(1, 0, 1, 6'd0, 6'd0, 6'd1, 6'd1);
        step();
        b2.io_input_reset = 1'b0;
        for (int i = 0; i < 66; i++) step();
        chk("wraps_sat", 64'(b2.io_output_wraps), 64'd63);
`endif

        // Single level, full 6-bit range with stride 1.
        b1.io_input_reset = 1'b1;
        step();
        b1.io_input_reset  = 1'b0;
        b1.io_input_enable = 1'b1;
        chk("l1_start", 64'(b1.io_output_counts), 64'd0);
        chk("l1_start_done", 64'(b1.io_output_done), 64'd0);
        for (int k = 1; k <= 64; k++) begin
            step();
            e = 6'(k % 64);
            chk($sformatf("l1_cnt%0d", k), 64'(b1.io_output_counts), 64'(e));
            chk($sformatf("l1_done%0d", k), 64'(b1.io_output_done), 64'(e == 6'd63));
        end

        // Stride 5: 60 wraps to 0 with no out-of-range value.
        b1.io_input_reset   = 1'b1;
        b1.io_input_strides = 6'd5;
        step();
        b1.io_input_reset = 1'b0;
        for (int k = 1; k <= 13; k++) begin
            step();
            e = (5 * k > 63) ? 6'd0 : 6'(5 * k);
            chk($sformatf("l1s5_cnt%0d", k), 64'(b1.io_output_counts), 64'(e));
            chk($sformatf("l1s5_done%0d", k), 64'(b1.io_output_done), 64'((7'(e) + 7'd5) > 7'd63));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/counter_chain.md
Name: counter_chain

Overview:
Parametrised successor to the single fixed 6-bit counter: a chain of LEVELS nested counters. Each level has a runtime-programmable max and stride; level 0 is innermost. Provides per-level and whole-chain done flags, plus an optional saturate (stop-at-end) mode. Drives loop-index generation for pipelined compute units; sits between controller FSMs and address generators.

Parameters:
LEVELS, 2, number of nested counter levels (1..8)
WIDTH, 6, bit width of each level's count, max and stride (2..32)

Ports:
clock  input  1  system clock, all state updates on rising edge
reset  input  1  synchronous active-high reset; clears all state
io_input_reset  input  1  synchronous active-high soft clear; same effect as reset
io_input_enable  input  1  advance the chain this cycle
io_input_saturate  input  1  1 = hold at final value on completion; 0 = wrap
io_input_maxes  input  LEVELS*WIDTH  per-level inclusive max; level i at bits [i*WIDTH +: WIDTH]
io_input_strides  input  LEVELS*WIDTH  per-level increment; same packing
io_output_counts  output  LEVELS*WIDTH  current per-level counts; same packing
io_output_dones  output  LEVELS  bit i = levels 0..i all at last value
io_output_done  output  1  = io_output_dones[LEVELS-1]
io_output_saturated  output  1  chain halted in saturate mode

Behaviour:
- Reset or io_input_reset: all counts = 0, saturated = 0 on the next edge. Both take priority over enable and saturate. Outputs are registered or derived from registers, so done = (max < stride) evaluated at counts 0.
- Effective stride: s_i = stride_i, or 1 when stride_i == 0.
- last_i = (count_i + s_i > max_i). The sum is evaluated in WIDTH+1 bits, so there is no overflow at max = 2^WIDTH-1.
- dones[i] = last_0 & ... & last_i. This is combinational from state and live inputs; it is not gated by enable.
- adv_0 = enable & !saturated. adv_i = adv_{i-1} & last_{i-1}.
- On adv_i: count_i <= last_i ? 0 : count_i + s_i. Without adv_i, count_i holds.
- Saturate: if adv_0 & io_output_done & io_input_saturate, counts hold (no wrap) and saturated <= 1.
- While saturated = 1: counts frozen, io_output_done stays 1, enable is ignored. Cleared only by reset or io_input_reset.
- Wrap mode (saturate = 0): when io_output_done & enable, all levels return to 0 on the next edge. done is then high for exactly one enabled step.
- Max/stride are sampled live each cycle:
  - If max drops below the current count, that level is at last and wraps on its next advance.
  - max_i = 0 keeps level i at 0 with last_i = 1.
- Counts never exceed max_i when max and stride are static from reset.
- LEVELS = 1, max = 63, stride = 1, saturate = 0 reproduces the legacy single-counter count sequence.

Optional Feature:
Macro COUNTER_CHAIN_WRAP_COUNT_EN.
- Defined: adds output io_output_wraps, WIDTH bits, reset 0. It increments on every full-chain wrap (adv_0 & io_output_done & !io_input_saturate) and saturates at 2^WIDTH-1 (no rollover). It is cleared by reset and io_input_reset.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- LEVELS=2, WIDTH=6, maxes {inner 3, outer 2}, strides {1,1}, enable held, saturate 0 -> counts step (0,0),(1,0),(2,0),(3,0),(0,1)...(3,2). dones[0] is high at inner 3; io_output_done is high only at (3,2). Counts return to (0,0) on cycle 12.
- Inner max 5, stride 2 -> inner sequence 0,2,4,0 (4+2=6>5). Outer increments on each inner wrap. Inner stride 0 behaves as stride 1.
- Saturate=1 reaching (3,2) with enable -> counts stay (3,2), saturated=1 from the next cycle, done held high across 10 further enabled cycles. io_input_reset=1 -> (0,0), saturated=0.
- Enable low mid-count at (2,1) for 5 cycles -> counts hold. io_input_reset and enable high together -> counts (0,0), reset wins. reset asserted mid-run -> same result.
- LEVELS=1, WIDTH=6, max 63, stride 1 -> 0..63 then 0; done high only at 63. With max 63 and stride 5: 60 -> 0, no 6-bit overflow value appears.
- COUNTER_CHAIN_WRAP_COUNT_EN defined, run the first scenario for 3 full periods -> io_output_wraps = 3. Force 2^WIDTH+2 wraps -> value holds at 63.
